// File: rtl/aux_pkg.sv
// Shared types and constants for the aux buffer hex dump reader.
package aux_pkg;

    localparam int unsigned CPU_ELEMENTS           = 10;
    localparam int unsigned INSTR_ELEMENTS         = 10;
    localparam int unsigned DATA_ELEMENTS          = 10;
    localparam int unsigned MEMORY_ELEMENTS        = INSTR_ELEMENTS + DATA_ELEMENTS;
    localparam int unsigned TOTAL_ELEMENTS_DEFAULT = CPU_ELEMENTS + MEMORY_ELEMENTS;
    localparam int unsigned NIBBLES_PER_WORD       = 4;
    localparam int unsigned CHAR_INDEX_WIDTH       = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/hex_ascii_encoder.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_ascii_encoder
    import aux_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);

    assign ascii_c = nibble_to_ascii(nibble);

endmodule

// File: rtl/aux_reader.sv
// Walks the aux buffer once per frame and streams every word as four hex
// characters (MS nibble first) over a valid/ready character interface.
module aux_reader
    import aux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned AUX_ADDRESS_WIDTH = 5,
    parameter int unsigned TOTAL_ELEMENTS    = TOTAL_ELEMENTS_DEFAULT
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         frame_start_in,
    output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
    input  logic [DATA_WIDTH-1:0]        aux_data_in,
    output logic [7:0]                   char_out,
    output logic                         char_valid_out,
    input  logic                         char_ready_in,
    output logic [CHAR_INDEX_WIDTH-1:0]  char_index_out,
    output logic                         busy_out,
    output logic                         done_out
);

    localparam int unsigned AW = AUX_ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned IW = CHAR_INDEX_WIDTH;

    state_t          state_q, state_d;
    logic [AW-1:0]   entry_q, entry_d;
    logic [IW-1:0]   index_q, index_d;
    logic [DW-1:0]   word_q, word_d;
    logic [1:0]      nib_q, nib_d;
    logic [7:0]      char_q, char_d;
    logic            valid_q, busy_q, done_q;
    logic [3:0]      enc_nibble;
    logic [7:0]      enc_char_c;
    logic            xfer;

    hex_ascii_encoder u_encoder (
        .nibble  (enc_nibble),
        .ascii_c (enc_char_c)
    );

    assign xfer = valid_q & char_ready_in;

    // Next-state and datapath: the word is shifted left so the character
    // being prepared always comes from a fixed bit position.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        index_d    = index_q;
        word_d     = word_q;
        nib_d      = nib_q;
        char_d     = char_q;
        enc_nibble = word_q[DW-5 -: 4];

        case (state_q)
            ST_IDLE: begin
                if (frame_start_in) begin
                    state_d = ST_FETCH;
                    entry_d = '0;
                    index_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                word_d     = aux_data_in;
                nib_d      = '0;
                enc_nibble = aux_data_in[DW-1 -: 4];
                char_d     = enc_char_c;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (nib_q == 2'(NIBBLES_PER_WORD - 1)) begin
                        if (entry_q < AW'(TOTAL_ELEMENTS - 1)) begin
                            entry_d = entry_q + AW'(1);
                            index_d = index_q + IW'(1);
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        nib_d   = nib_q + 2'd1;
                        word_d  = word_q << 4;
                        char_d  = enc_char_c;
                        index_d = index_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            entry_q <= '0;
            index_q <= '0;
            word_q  <= '0;
            nib_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            index_q <= index_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
            char_q  <= char_d;
            valid_q <= (state_d == ST_EMIT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign aux_raddress_out = entry_q;
    assign char_out         = char_q;
    assign char_valid_out   = valid_q;
    assign char_index_out   = index_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;

endmodule

// File: tb/tb_aux_reader.sv
// Directed bench for aux_reader: full dumps, stall, ignored restart, mid-frame reset.
module tb_aux_reader;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 5;
    localparam int unsigned TE  = 30;
    localparam int          NCH = 4 * TE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [7:0]    ch;
    logic          valid;
    logic [6:0]    idx;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:31];

    always #5 clk = ~clk;

    // Synchronous-read buffer model: data follows the address by one cycle.
    always @(posedge clk) rdata <= mem[raddr];

    aux_reader #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .TOTAL_ELEMENTS    (TE)
    ) dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .frame_start_in   (start),
        .aux_raddress_out (raddr),
        .aux_data_in      (rdata),
        .char_out         (ch),
        .char_valid_out   (valid),
        .char_ready_in    (ready),
        .char_index_out   (idx),
        .busy_out         (busy),
        .done_out         (done)
    );

    int    errors = 0;
    int    checks = 0;
    string hexdig = "0123456789ABCDEF";
    byte   got [0:NCH-1];
    int    xfers, dones, first_n, done_n, gaps, seq_err, hold_err, stall_left;
    int    addr_at_fetch, busy_at_fetch;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: pulse start, then watch every cycle; optional stall,
    // restart attempt and mid-frame reset keyed on the character index.
    task automatic run_frame(input int stall_idx, input int restart_idx, input int reset_idx);
        int       n;
        int       reset_n_at;
        logic [7:0] hold_ch;
        logic [6:0] hold_idx;
        bit       restarted;
        bit       aborted;
        xfers = 0; dones = 0; first_n = -1; done_n = -1; gaps = 0;
        seq_err = 0; hold_err = 0; stall_left = 5;
        addr_at_fetch = -1; busy_at_fetch = -1;
        restarted = 0; aborted = 0; reset_n_at = 0;
        hold_ch = '0; hold_idx = '0;
        for (int k = 0; k < NCH; k++) got[k] = 8'h00;

        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (n < 400) begin
            if (n == 1) begin
                addr_at_fetch = int'(raddr);
                busy_at_fetch = int'(busy);
            end
            if (done) begin
                dones++;
                if (done_n < 0) done_n = n;
            end
            if (first_n < 0 && valid) first_n = n;
            if (first_n >= 0 && done_n < 0 && !valid && !done) gaps++;

            start = 1'b0;
            if (!restarted && restart_idx >= 0 && valid && int'(idx) == restart_idx) begin
                start = 1'b1;
                restarted = 1;
            end

            if (!aborted && reset_idx >= 0 && valid && int'(idx) == reset_idx) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_valid", int'(valid), 0);
                check("rst_mid_char", int'(ch), 0);
                check("rst_mid_index", int'(idx), 0);
                check("rst_mid_addr", int'(raddr), 0);
                check("rst_mid_busy", int'(busy), 0);
                check("rst_mid_done", int'(done), 0);
                aborted = 1;
                reset_n_at = n;
                step();
                rst_n = 1'b1;
                n++;
            end

            ready = 1'b1;
            if (valid && stall_idx >= 0 && int'(idx) == stall_idx && stall_left > 0) begin
                if (stall_left == 5) begin
                    hold_ch  = ch;
                    hold_idx = idx;
                end else if (ch !== hold_ch || idx !== hold_idx) begin
                    hold_err++;
                end
                ready = 1'b0;
                stall_left--;
            end

            if (valid && ready) begin
                if (int'(idx) != xfers) seq_err++;
                if (xfers < NCH) got[xfers] = byte'(ch);
                xfers++;
            end

            if (done_n >= 0 && n >= done_n + 4) break;
            if (aborted && n >= reset_n_at + 12) break;
            step();
            n++;
        end
        start = 1'b0;
    endtask

    function automatic int char_errors();
        int         m;
        logic [3:0] nib;
        m = 0;
        for (int k = 0; k < NCH; k++) begin
            nib = 4'(mem[k / 4] >> (12 - 4 * (k % 4)));
            if (got[k] !== hexdig[nib]) m++;
        end
        return m;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'(16'h1000 + i);
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        #1;
        check("reset_valid", int'(valid), 0);
        check("reset_char", int'(ch), 0);
        check("reset_index", int'(idx), 0);
        check("reset_addr", int'(raddr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (3) step();
        check("idle_ready_no_effect", int'(valid) + int'(busy), 0);

        // Frame 1: entries 0x1000+i, ready always high.
        run_frame(-1, -1, -1);
        check("f1_first_valid", first_n, 3);
        check("f1_fetch_addr", addr_at_fetch, 0);
        check("f1_fetch_busy", busy_at_fetch, 1);
        check("f1_count", xfers, 120);
        check("f1_sequence", seq_err, 0);
        check("f1_done_pulses", dones, 1);
        check("f1_cycles_incl_start", done_n + 1, 182);
        check("f1_gap_cycles", gaps, 58);
        check("f1_c0", int'(got[0]), 8'h31);
        check("f1_c1", int'(got[1]), 8'h30);
        check("f1_c2", int'(got[2]), 8'h30);
        check("f1_c3", int'(got[3]), 8'h30);
        check("f1_c116", int'(got[116]), 8'h31);
        check("f1_c117", int'(got[117]), 8'h30);
        check("f1_c118", int'(got[118]), 8'h31);
        check("f1_c119", int'(got[119]), 8'h44);
        check("f1_all_chars", char_errors(), 0);
        check("f1_idle_busy", int'(busy), 0);

        // Frame 2: entry 0 = ABCF, ready stalled 5 cycles at index 2.
        mem[0] = 16'hABCF;
        run_frame(2, -1, -1);
        check("f2_first_valid", first_n, 3);
        check("f2_c0", int'(got[0]), 8'h41);
        check("f2_c1", int'(got[1]), 8'h42);
        check("f2_c2", int'(got[2]), 8'h43);
        check("f2_c3", int'(got[3]), 8'h46);
        check("f2_stall_done", stall_left, 0);
        check("f2_stall_hold", hold_err, 0);
        check("f2_sequence", seq_err, 0);
        check("f2_count", xfers, 120);
        check("f2_all_chars", char_errors(), 0);
        check("f2_cycles_incl_start", done_n + 1, 187);

        // Frame 3: second start pulse at index 40 is ignored.
        run_frame(-1, 40, -1);
        check("f3_count", xfers, 120);
        check("f3_sequence", seq_err, 0);
        check("f3_done_pulses", dones, 1);
        check("f3_cycles_incl_start", done_n + 1, 182);
        check("f3_all_chars", char_errors(), 0);

        // Frame 4: reset at index 57 aborts without done.
        run_frame(-1, -1, 57);
        check("f4_count", xfers, 57);
        check("f4_sequence", seq_err, 0);
        check("f4_done_pulses", dones, 0);
        check("f4_idle_busy", int'(busy), 0);

        // Frame 5: fresh start after the abort restarts from index/address 0.
        run_frame(-1, -1, -1);
        check("f5_fetch_addr", addr_at_fetch, 0);
        check("f5_first_valid", first_n, 3);
        check("f5_sequence", seq_err, 0);
        check("f5_c0", int'(got[0]), 8'h41);
        check("f5_count", xfers, 120);
        check("f5_done_pulses", dones, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aux_reader.md
AUX_READER -- requirements
Module: aux_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, aux buffer word width.
REQ-002 SHALL have parameter AUX_ADDRESS_WIDTH, default 5, aux buffer address width.
REQ-003 SHALL have parameter TOTAL_ELEMENTS, default 30, entries per frame (10 CPU + 10 instruction + 10 data).
REQ-004 SHALL have port clock_in  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_start_in  input  1  one-cycle pulse requesting a full buffer dump.
REQ-007 SHALL have port aux_raddress_out  output  AUX_ADDRESS_WIDTH  aux buffer read address.
REQ-008 SHALL have port aux_data_in  input  DATA_WIDTH  aux buffer read data, valid one cycle after address.
REQ-009 SHALL have port char_out  output  8  ASCII hex character.
REQ-010 SHALL have port char_valid_out  output  1  char_out/char_index_out valid.
REQ-011 SHALL have port char_ready_in  input  1  downstream text renderer accepts the character.
REQ-012 SHALL have port char_index_out  output  7  character position 0..4*TOTAL_ELEMENTS-1.
REQ-013 SHALL have port busy_out  output  1  high when not in IDLE.
REQ-014 SHALL have port done_out  output  1  one-cycle pulse after last character accepted.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, EMIT, DONE.
REQ-016 IDLE: frame_start_in high -> FETCH, entry counter and char index cleared to 0.
REQ-017 FETCH: aux_raddress_out equals entry counter; next state LOAD unconditionally.
REQ-018 LOAD: aux_data_in captured into word register at end of cycle; nibble counter cleared; next state EMIT.
REQ-019 EMIT: char_valid_out high; char_out = ASCII of current nibble, most significant nibble first.
REQ-020 Nibble encoding: 0x0-0x9 -> 0x30-0x39, 0xA-0xF -> 0x41-0x46 (uppercase).
REQ-021 Handshake: transfer occurs on a cycle with char_valid_out and char_ready_in both high; char_out, char_index_out held stable until transfer.
REQ-022 On each transfer char_index_out increments by 1 and nibble counter advances.
REQ-023 Transfer of 4th nibble: entry counter < TOTAL_ELEMENTS-1 -> increment entry counter, go FETCH; else go DONE.
REQ-024 DONE: done_out high for exactly one cycle; next state IDLE.
REQ-025 Latency: frame_start_in sampled high at edge N -> char_valid_out high from cycle after edge N+2 (3 cycles).
REQ-026 Inter-entry gap: exactly 2 cycles (FETCH, LOAD) with char_valid_out low between entries.
REQ-027 frame_start_in while busy_out high SHALL be ignored; no restart, no queueing.
REQ-028 char_ready_in high while char_valid_out low SHALL have no effect.
REQ-029 char_valid_out SHALL never be high outside EMIT; busy_out high in FETCH, LOAD, EMIT, DONE.
REQ-030 Entry counter and char index SHALL never wrap within a frame; final char_index_out = 4*TOTAL_ELEMENTS-1 (119 default).

Reset
REQ-031 reset_n_in low SHALL immediately force IDLE, aux_raddress_out=0, char_out=0, char_valid_out=0, char_index_out=0, busy_out=0, done_out=0, word register=0.
REQ-032 Reset asserted mid-frame SHALL abort the dump; no done_out pulse; new frame only on subsequent frame_start_in.

Structure
REQ-033 Shared package aux_pkg SHALL hold the state enum, TOTAL_ELEMENTS default, CPU/MEMORY element counts and the nibble-to-ASCII function.
REQ-034 Sub-module hex_ascii_encoder (4-bit in, 8-bit out, combinational) SHALL implement REQ-020; the rest remains in aux_reader.

Verification
REQ-035 Buffer preloaded entry i = 16'h1000+i, ready tied high, start pulse -> 120 chars, first four "1000" (0x31,0x30,0x30,0x30), last four "101D", done_out one cycle after index 119 transfer.
REQ-036 Entry 0 = 16'hABCF -> chars 0x41,0x42,0x43,0x46 at indices 0-3; first valid exactly 3 cycles after start.
REQ-037 char_ready_in low 5 cycles with valid high at index 2 -> char_out and index held constant, no skipped or duplicated characters.
REQ-038 Second frame_start_in pulse at index 40 -> ignored; dump completes with 120 characters and one done_out.
REQ-039 reset_n_in low at index 57 -> all outputs zero same cycle, no done_out; new start -> index restarts at 0, address 0.
REQ-040 Ready always high -> cycles from start to done_out = 3 + 30*4 + 29*2 + 1 = 182.
